// File: rtl/ahb_master.sv
// ahb_master: AHB-Lite master that turns a valid/ready load/store stream into pipelined
// single NONSEQ transfers, with overlapped address/data phases and in-order responses.
// Optional feature: define AHB_MASTER_LANE_ALIGN_EN for byte-lane steering of write/read
// data and local rejection of misaligned requests.
module ahb_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_size,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic                  hwrite,
   output logic [2:0]            hsize,
   output logic [1:0]            htrans,
   output logic [2:0]            hburst,
   output logic [3:0]            hprot,
   output logic                  hmastlock,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hready,
   input  logic                  hresp
);

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;

   // Address-phase stage
   logic                  ap_valid, ap_write, ap_mis;
   logic [ADDR_WIDTH-1:0] ap_addr;
   logic [2:0]            ap_size;
   logic [DATA_WIDTH-1:0] ap_wdata;
   // Data-phase stage
   logic                  dp_valid, dp_write, dp_mis;
   logic [1:0]            dp_lo;
   logic [2:0]            dp_size;
   logic [DATA_WIDTH-1:0] dp_wdata;
   // Set between the two cycles of a two-cycle ERROR response
   logic                  hold;

   logic                  issue, accept, req_mis, dp_done;
   logic [DATA_WIDTH-1:0] wdata_fmt, rdata_fmt;

   assign issue     = ap_valid & ~hold & ~ap_mis;
   assign req_ready = HRESETn & ~hold & (~ap_valid | hready);
   assign accept    = req_valid & req_ready;
   assign dp_done   = dp_valid & hready;

   assign htrans    = issue ? HtransNonseq : HtransIdle;
   assign haddr     = ap_addr;
   assign hwrite    = ap_write;
   assign hsize     = ap_size;
   assign hwdata    = dp_wdata;
   assign hburst    = 3'b000;
   assign hprot     = 4'b0011;
   assign hmastlock = 1'b0;

`ifdef AHB_MASTER_LANE_ALIGN_EN
   logic [DATA_WIDTH-1:0] rd_shift;
   assign rd_shift = hrdata >> {dp_lo, 3'b000};

   // Lane steering of store data, misalignment check and load data extraction
   always_comb begin
      req_mis   = 1'b0;
      wdata_fmt = req_wdata;
      rdata_fmt = rd_shift;
      case (req_size)
         3'b000:  wdata_fmt = {4{req_wdata[7:0]}};
         3'b001: begin
            wdata_fmt = {2{req_wdata[15:0]}};
            req_mis   = req_addr[0];
         end
         3'b010:  req_mis = |req_addr[1:0];
         default: ;
      endcase
      case (dp_size)
         3'b000:  rdata_fmt = {24'h0, rd_shift[7:0]};
         3'b001:  rdata_fmt = {16'h0, rd_shift[15:0]};
         default: ;
      endcase
   end
`else
   logic unused_lane;
   assign unused_lane = ^{dp_lo, dp_size};

   // Data passes in-lane; no alignment check
   always_comb begin
      req_mis   = 1'b0;
      wdata_fmt = req_wdata;
      rdata_fmt = hrdata;
   end
`endif

   // Pipeline: AP advances into DP on hready; hold freezes AP across an ERROR
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_valid <= 1'b0;
         ap_write <= 1'b0;
         ap_mis   <= 1'b0;
         ap_addr  <= '0;
         ap_size  <= 3'b000;
         ap_wdata <= '0;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_mis   <= 1'b0;
         dp_lo    <= 2'b00;
         dp_size  <= 3'b000;
         dp_wdata <= '0;
      end else if (hready) begin
         // A misaligned entry takes a pseudo data phase so its error stays in order
         dp_valid <= ap_valid & ~hold;
         if (ap_valid && !hold) begin
            dp_write <= ap_write;
            dp_mis   <= ap_mis;
            dp_lo    <= ap_addr[1:0];
            dp_size  <= ap_size;
            dp_wdata <= ap_wdata;
         end
         if (accept) begin
            ap_valid <= 1'b1;
            ap_write <= req_write;
            ap_mis   <= req_mis;
            ap_addr  <= req_addr;
            ap_size  <= req_size;
            ap_wdata <= wdata_fmt;
         end else if (!hold) begin
            ap_valid <= 1'b0;
         end
      end
   end

   // First ERROR cycle sets hold; the completing second cycle clears it
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold <= 1'b0;
      end else if (hready) begin
         hold <= 1'b0;
      end else if (dp_valid && hresp && !dp_mis) begin
         hold <= 1'b1;
      end
   end

   // Registered response, one cycle after data-phase completion
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= dp_done;
         rsp_err   <= dp_done & (hresp | dp_mis);
         rsp_rdata <= (dp_done && !dp_write && !hresp && !dp_mis) ? rdata_fmt : '0;
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: scoreboard bench for ahb_master with a small behavioural AHB slave
// (memory, programmable wait states and two-cycle ERROR on one address).
module tb_ahb_master;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hready, hresp, hmastlock;
   logic [2:0]  hsize, hburst;
   logic [1:0]  htrans;
   logic [3:0]  hprot;

   ahb_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
      .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          extra_rsp = 0;
   logic [31:0] model_mem [16];

   // Slave model
   logic [31:0] mem [16];
   logic        dph_valid, dph_write;
   logic [31:0] dph_addr;
   int          wcnt;
   logic        err_en;
   logic [31:0] err_addr, wait_addr;
   int          wait_n;

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = (dph_valid && !dph_write) ? mem[dph_addr[5:2]] : 32'h0;
      if (dph_valid && err_en && dph_addr == err_addr) begin
         hresp  = 1'b1;
         hready = (wcnt != 0);
      end else if (dph_valid && dph_addr == wait_addr && wcnt < wait_n) begin
         hready = 1'b0;
      end
   end

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dph_valid <= 1'b0;
         dph_write <= 1'b0;
         dph_addr  <= 32'h0;
         wcnt      <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h7F00_0000;
         mem[4] <= 32'hDEAD_BEEF;
      end else if (hready) begin
         if (dph_valid && dph_write && !hresp) mem[dph_addr[5:2]] <= hwdata;
         dph_valid <= (htrans == 2'b10);
         dph_addr  <= haddr;
         dph_write <= hwrite;
         wcnt      <= 0;
      end else begin
         wcnt <= wcnt + 1;
      end
   end

   // Advance one cycle; compare any response against the scoreboard head
   task automatic tick();
      rsp_t e;
      @(posedge HCLK);
      #1;
      cyc++;
      if (rsp_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            extra_rsp++;
            $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response",
                     rsp_err, rsp_rdata);
         end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
               errors++;
               $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                        rsp_err, rsp_rdata, e.err, e.rdata);
            end
         end
      end
   endtask

   // Present one request; returns in the cycle after acceptance (its address phase)
   task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
      int   n = 0;
      rsp_t e;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_size  = s;
      req_wdata = d;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL req_accept: got req_ready=%b, required 1 within 50 cycles", req_ready);
      end else begin
         e.err   = e_err;
         e.rdata = e_rd;
         sb.push_back(e);
         if (w && !e_err) model_mem[a[5:2]] = d;
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      HRESETn   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_size  = 3'b000;
      req_wdata = 32'h0;
      err_en    = 1'b0;
      err_addr  = 32'h0001_0000;
      wait_addr = 32'hFFFF_FFFF;
      wait_n    = 0;
      for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
      model_mem[0] = 32'h7F00_0000;
      model_mem[4] = 32'hDEAD_BEEF;
      repeat (2) @(posedge HCLK);
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 0", req_ready);
      end
      checks++;
      if ({htrans, haddr, hwrite, hsize, hwdata} !== 70'h0) begin
         errors++;
         $display("FAIL reset_bus: got htrans=%b haddr=%h hwrite=%b hsize=%b hwdata=%h, required 0",
                  htrans, haddr, hwrite, hsize, hwdata);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
         errors++;
         $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h, required 0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      checks++;
      if (hburst !== 3'b000 || hprot !== 4'b0011 || hmastlock !== 1'b0) begin
         errors++;
         $display("FAIL const_outs: got hburst=%b hprot=%b hmastlock=%b, required 000 0011 0",
                  hburst, hprot, hmastlock);
      end
      HRESETn = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b, required 1", req_ready);
      end
   endtask

   task automatic test_basic_load();
      send(1'b0, 32'h0000_0010, 3'b010, 32'h0, 1'b0, 32'hDEAD_BEEF);
      checks++;
      if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b0) begin
         errors++;
         $display("FAIL basic_ap: got htrans=%b haddr=%h hwrite=%b, required 10 00000010 0",
                  htrans, haddr, hwrite);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_rsp: got rsp_valid=%b at N+2, required 0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: got rsp_valid=%b at N+3, required 1", rsp_valid);
      end
      drain("basic");
   endtask

`ifdef AHB_MASTER_LANE_ALIGN_EN
   task automatic test_lane_align();
      send(1'b0, 32'h3, 3'b000, 32'h0, 1'b0, 32'h0000_007F);
      drain("lane_load");
      send(1'b1, 32'h3, 3'b000, 32'h0000_00A5, 1'b0, 32'h0);
      tick();
      checks++;
      if (hwdata !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL lane_wdata: got %h, required a5a5a5a5", hwdata);
      end
      send(1'b0, 32'h2, 3'b010, 32'h0, 1'b1, 32'h0);
      checks++;
      if (htrans !== 2'b00) begin
         errors++;
         $display("FAIL lane_misaligned_bus: got htrans=%b, required 00", htrans);
      end
      drain("lane");
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] wd [4];
      int          start;
      wd[0] = 32'h1111_2222;
      wd[1] = 32'h3333_4444;
      wd[2] = 32'h5555_6666;
      wd[3] = 32'h7777_8888;
      start = cyc;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 32'(i * 4), 3'b010, wd[i], 1'b0, 32'h0);
         checks++;
         if (htrans !== 2'b10 || haddr !== 32'(i * 4)) begin
            errors++;
            $display("FAIL b2b_store_ap%0d: got htrans=%b haddr=%h, required 10 %h",
                     i, htrans, haddr, 32'(i * 4));
         end
         if (i > 0) begin
            checks++;
            if (hwdata !== wd[i-1]) begin
               errors++;
               $display("FAIL b2b_hwdata%0d: got %h, required %h", i - 1, hwdata, wd[i-1]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 32'(i * 4), 3'b010, 32'h0, 1'b0, model_mem[i]);
         if (i == 0) begin
            checks++;
            if (hwdata !== wd[3]) begin
               errors++;
               $display("FAIL b2b_hwdata3: got %h, required %h", hwdata, wd[3]);
            end
         end
      end
      checks++;
      if (cyc - start != 8) begin
         errors++;
         $display("FAIL b2b_throughput: got %0d cycles for 8 requests, required 8", cyc - start);
      end
      drain("b2b");
   endtask

   task automatic test_wait_states();
      wait_addr = 32'h4;
      wait_n    = 2;
      send(1'b0, 32'h0, 3'b010, 32'h0, 1'b0, model_mem[0]);
      send(1'b0, 32'h4, 3'b010, 32'h0, 1'b0, model_mem[1]);
      send(1'b0, 32'h8, 3'b010, 32'h0, 1'b0, model_mem[2]);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (req_ready !== 1'b0 || haddr !== 32'h8 || htrans !== 2'b10) begin
            errors++;
            $display("FAIL wait_hold%0d: got req_ready=%b haddr=%h htrans=%b, required 0 8 10",
                     k, req_ready, haddr, htrans);
         end
         tick();
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_early_rsp: got rsp_valid=%b, required 0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_delayed_rsp: got rsp_valid=%b, required 1", rsp_valid);
      end
      wait_addr = 32'hFFFF_FFFF;
      drain("wait");
   endtask

   task automatic test_error();
      err_en = 1'b1;
      send(1'b1, 32'h0001_0000, 3'b010, 32'hBAD0_BAD0, 1'b1, 32'h0);
      send(1'b0, 32'h4, 3'b010, 32'h0, 1'b0, model_mem[1]);
      tick();
      checks++;
      if (htrans !== 2'b00 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL err_cancel: got htrans=%b req_ready=%b, required 00 0", htrans, req_ready);
      end
      tick();
      checks++;
      if (htrans !== 2'b10 || haddr !== 32'h4) begin
         errors++;
         $display("FAIL err_reissue: got htrans=%b haddr=%h, required 10 00000004", htrans, haddr);
      end
      drain("error");
      err_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      send(1'b1, 32'h8, 3'b010, 32'h5555_AAAA, 1'b0, 32'h0);
      send(1'b0, 32'hC, 3'b010, 32'h0, 1'b0, model_mem[3]);
      HRESETn = 1'b0;
      #1;
      checks++;
      if ({htrans, haddr, hwrite, hsize, hwdata} !== 70'h0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_bus: got htrans=%b haddr=%h hwdata=%h req_ready=%b, required 0",
                  htrans, haddr, hwdata, req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
         errors++;
         $display("FAIL midreset_rsp: got valid=%b err=%b rdata=%h, required 0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      sb.delete();
      repeat (3) tick();
      HRESETn   = 1'b1;
      extra_rsp = 0;
      repeat (8) tick();
      checks++;
      if (extra_rsp != 0) begin
         errors++;
         $display("FAIL midreset_no_rsp: got %0d responses, required 0", extra_rsp);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
`ifdef AHB_MASTER_LANE_ALIGN_EN
      test_lane_align();
`endif
      test_back_to_back();
      test_wait_states();
      test_error();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
